fp_vec_accum_ctrl: RTL

FP_VEC_ACCUM_CTRL -- requirements
Module: fp_vec_accum_ctrl

---
 rtl/fp_vec_accum_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/fp_vec_accum_ctrl.sv
// fp_vec_accum_ctrl
// Sequences a shared FP adder tree over num_chunks 32-element chunks.
// Each chunk is fetched, reduced by the tree, then folded into a running
// accumulator through the tree's final stage. All outputs are registered and
// are decoded from the next state so that each strobe lines up with the
// state it belongs to.
module fp_vec_accum_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_W      = 8,
   parameter int TIMEOUT    = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [CNT_W-1:0]      num_chunks,
   input  logic                  op_sel,
   input  logic                  abort,
   output logic                  chunk_req,
   input  logic                  chunk_vld,
   output logic                  comp_en,
   output logic                  data_in_op_sel,
   output logic                  accum_comp_en,
   output logic [DATA_WIDTH-1:0] cur_accum_data,
   output logic [DATA_WIDTH-1:0] accum_add_data,
   input  logic [DATA_WIDTH-1:0] sum_data,
   input  logic                  sum_vld,
   output logic [DATA_WIDTH-1:0] result_data,
   output logic                  result_vld,
   output logic                  busy,
   output logic                  err_timeout
);

   localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_REQ       = 3'd1,
      ST_ISSUE     = 3'd2,
      ST_WAIT_TREE = 3'd3,
      ST_ACCUM     = 3'd4,
      ST_WAIT_ACC  = 3'd5,
      ST_DONE      = 3'd6
   } state_t;

   state_t                state_r, state_nxt_s;
   logic [CNT_W-1:0]      num_r, num_nxt_s;
   logic [CNT_W-1:0]      idx_r, idx_nxt_s;
   logic [CNT_W:0]        idx_inc_s;
   logic                  more_s;
   logic                  op_r, op_nxt_s;
   logic [TMR_W-1:0]      tmr_r, tmr_nxt_s;
   logic                  tmo_s;
   logic                  err_nxt_s;
   logic [DATA_WIDTH-1:0] acc_r, acc_nxt_s;
   logic [DATA_WIDTH-1:0] csum_r, csum_nxt_s;
   logic [DATA_WIDTH-1:0] cur_nxt_s, add_nxt_s, res_nxt_s;

   // Index is widened by one bit so the last-chunk compare cannot wrap at 2^CNT_W-1.
   assign idx_inc_s = {1'b0, idx_r} + {{CNT_W{1'b0}}, 1'b1};
   assign more_s    = (idx_inc_s < {1'b0, num_r});
   assign tmo_s     = (tmr_r == TMR_W'(TIMEOUT - 1));

   // Next-state, datapath-update and output decode.
   always_comb begin
      state_nxt_s = state_r;
      num_nxt_s   = num_r;
      idx_nxt_s   = idx_r;
      op_nxt_s    = op_r;
      tmr_nxt_s   = tmr_r;
      err_nxt_s   = err_timeout;
      acc_nxt_s   = acc_r;
      csum_nxt_s  = csum_r;

      case (state_r)
         ST_IDLE: begin
            if (start) begin
               num_nxt_s   = num_chunks;
               op_nxt_s    = op_sel;
               idx_nxt_s   = {CNT_W{1'b0}};
               tmr_nxt_s   = {TMR_W{1'b0}};
               err_nxt_s   = 1'b0;
               acc_nxt_s   = {DATA_WIDTH{1'b0}};
               csum_nxt_s  = {DATA_WIDTH{1'b0}};
               state_nxt_s = (num_chunks != {CNT_W{1'b0}}) ? ST_REQ : ST_DONE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (abort) begin
               state_nxt_s = ST_IDLE;
            end else if (chunk_vld) begin
               state_nxt_s = ST_ISSUE;
            end else begin
               state_nxt_s = ST_REQ;
            end
         end
         ST_ISSUE: begin
            tmr_nxt_s   = {TMR_W{1'b0}};
            state_nxt_s = abort ? ST_IDLE : ST_WAIT_TREE;
         end
         ST_WAIT_TREE: begin
            if (abort) begin
               state_nxt_s = ST_IDLE;
            end else if (sum_vld) begin
               csum_nxt_s = sum_data;
               if (idx_r == {CNT_W{1'b0}}) begin
                  // First chunk seeds the accumulator; no tree accumulate needed.
                  acc_nxt_s   = sum_data;
                  idx_nxt_s   = idx_inc_s[CNT_W-1:0];
                  state_nxt_s = more_s ? ST_REQ : ST_DONE;
               end else begin
                  state_nxt_s = ST_ACCUM;
               end
            end else if (tmo_s) begin
               err_nxt_s   = 1'b1;
               state_nxt_s = ST_IDLE;
            end else begin
               tmr_nxt_s = tmr_r + TMR_W'(1);
            end
         end
         ST_ACCUM: begin
            tmr_nxt_s   = {TMR_W{1'b0}};
            state_nxt_s = abort ? ST_IDLE : ST_WAIT_ACC;
         end
         ST_WAIT_ACC: begin
            if (abort) begin
               state_nxt_s = ST_IDLE;
            end else if (sum_vld) begin
               acc_nxt_s   = sum_data;
               idx_nxt_s   = idx_inc_s[CNT_W-1:0];
               state_nxt_s = more_s ? ST_REQ : ST_DONE;
            end else if (tmo_s) begin
               err_nxt_s   = 1'b1;
               state_nxt_s = ST_IDLE;
            end else begin
               tmr_nxt_s = tmr_r + TMR_W'(1);
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase

      // Accumulate operands are launched in ACCUM and held until the result returns.
      if (state_nxt_s == ST_ACCUM) begin
         cur_nxt_s = acc_r;
         add_nxt_s = csum_nxt_s;
      end else if (state_nxt_s == ST_WAIT_ACC) begin
         cur_nxt_s = cur_accum_data;
         add_nxt_s = accum_add_data;
      end else begin
         cur_nxt_s = {DATA_WIDTH{1'b0}};
         add_nxt_s = {DATA_WIDTH{1'b0}};
      end

      if (state_nxt_s == ST_DONE) begin
         res_nxt_s = acc_nxt_s;
      end else begin
         res_nxt_s = result_data;
      end
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= ST_IDLE;
         num_r          <= {CNT_W{1'b0}};
         idx_r          <= {CNT_W{1'b0}};
         op_r           <= 1'b0;
         tmr_r          <= {TMR_W{1'b0}};
         acc_r          <= {DATA_WIDTH{1'b0}};
         csum_r         <= {DATA_WIDTH{1'b0}};
         chunk_req      <= 1'b0;
         comp_en        <= 1'b0;
         accum_comp_en  <= 1'b0;
         data_in_op_sel <= 1'b0;
         cur_accum_data <= {DATA_WIDTH{1'b0}};
         accum_add_data <= {DATA_WIDTH{1'b0}};
         result_data    <= {DATA_WIDTH{1'b0}};
         result_vld     <= 1'b0;
         busy           <= 1'b0;
         err_timeout    <= 1'b0;
      end else begin
         state_r        <= state_nxt_s;
         num_r          <= num_nxt_s;
         idx_r          <= idx_nxt_s;
         op_r           <= op_nxt_s;
         tmr_r          <= tmr_nxt_s;
         acc_r          <= acc_nxt_s;
         csum_r         <= csum_nxt_s;
         chunk_req      <= (state_nxt_s == ST_REQ);
         comp_en        <= (state_nxt_s == ST_ISSUE);
         accum_comp_en  <= (state_nxt_s == ST_ACCUM);
         data_in_op_sel <= (state_nxt_s != ST_IDLE) & op_nxt_s;
         cur_accum_data <= cur_nxt_s;
         accum_add_data <= add_nxt_s;
         result_data    <= res_nxt_s;
         result_vld     <= (state_nxt_s == ST_DONE);
         busy           <= (state_nxt_s != ST_IDLE);
         err_timeout    <= err_nxt_s;
      end
   end

endmodule
